// File: rtl/muestreo_adc.sv
// rtl/muestreo_adc.sv - serial ADC sampler: one 16-SCLK framed read per rising edge of Clock_muestreo.
module muestreo_adc #(
  parameter int CLK_DIV = 25,
  parameter int NBITS   = 12
) (
  input  logic             Clck_in,
  input  logic             reset_Clock,
  input  logic             enable,
  input  logic             Clock_muestreo,
  input  logic             sdata,
  output logic             sclk,
  output logic             cs_n,
  output logic [NBITS-1:0] dato,
  output logic             dato_valido,
  output logic             ocupado,
  output logic             overrun
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ESPERA, TRANSFER, FIN, QUIET} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift_reg;
  logic          muestreo_q;
  logic          req;

  // Edge-detect copy resets high so a level already high at release is not a request.
  assign req = Clock_muestreo & ~muestreo_q;

  always_ff @(posedge Clck_in or negedge reset_Clock) begin
    if (!reset_Clock) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      muestreo_q  <= 1'b1;
      sclk        <= 1'b1;
      cs_n        <= 1'b1;
      dato        <= '0;
      dato_valido <= 1'b0;
      ocupado     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      muestreo_q  <= Clock_muestreo;
      dato_valido <= 1'b0;
      overrun     <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        shift_reg <= '0;
        sclk      <= 1'b1;
        cs_n      <= 1'b1;
        ocupado   <= 1'b0;
      end else begin
        if (req && state != IDLE) overrun <= 1'b1;
        case (state)
          IDLE: begin
            if (req) begin
              state   <= ESPERA;
              cs_n    <= 1'b0;
              ocupado <= 1'b1;
              div_cnt <= '0;
            end
          end
          ESPERA: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              bit_cnt <= '0;
              sclk    <= 1'b0;
              state   <= TRANSFER;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          TRANSFER: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (!sclk) begin
                sclk      <= 1'b1;
                shift_reg <= {shift_reg[14:0], sdata};
              end else if (bit_cnt == 4'd15) begin
                cs_n  <= 1'b1;
                state <= FIN;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sclk    <= 1'b0;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          FIN: begin
            dato        <= shift_reg[NBITS-1:0];
            dato_valido <= 1'b1;
            div_cnt     <= '0;
            state       <= QUIET;
          end
          QUIET: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              ocupado <= 1'b0;
              state   <= IDLE;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The leading bits of the frame are always zero from the ADC and are not reported.
  generate
    if (NBITS < 16) begin : g_lead
      logic unused_lead;
      assign unused_lead = ^shift_reg[15:NBITS];
    end
  endgenerate

endmodule

// File: tb/tb_muestreo_adc.sv
// tb/tb_muestreo_adc.sv - directed/random bench for muestreo_adc with an ADC model and frame-level reference.
module tb_muestreo_adc;

  localparam int D   = 25;
  localparam int LAT = 33 * D + 2;
  localparam int SP  = 34 * D + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cm = 1'b0;
  logic        sdata = 1'b0;
  logic        sclk, cs_n, dato_valido, ocupado, overrun;
  logic [11:0] dato;

  muestreo_adc dut (
    .Clck_in(clk), .reset_Clock(rst_n), .enable(enable), .Clock_muestreo(cm),
    .sdata(sdata), .sclk(sclk), .cs_n(cs_n), .dato(dato),
    .dato_valido(dato_valido), .ocupado(ocupado), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int rises = 0, cs_low = 0, dv_cnt = 0, dv_cyc = 0, ov_cnt = 0;
  int hi_run = 0, last_hi_run = 0;
  logic [11:0] dv_dato = '0;
  logic prev_sclk = 1'b1;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    if (sclk && !prev_sclk) rises <= rises + 1;
    if (!cs_n) begin
      cs_low <= cs_low + 1;
      if (hi_run != 0) last_hi_run <= hi_run;
      hi_run <= 0;
    end else begin
      hi_run <= hi_run + 1;
    end
    if (dato_valido) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_dato <= dato;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  // ADC model: presents the MSB on CS fall, the next bit on each SCLK fall.
  logic [15:0] adc_word = '0;
  int          idx = 0;
  always @(negedge sclk or negedge cs_n) begin
    if (sclk) begin
      idx   = 0;
      sdata = adc_word[15];
    end else if (!cs_n && idx < 16) begin
      sdata = adc_word[15 - idx];
      idx   = idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int req_cyc = 0;
  task automatic request();
    if (cm) begin
      cm = 1'b0;
      step();
    end
    cm = 1'b1;
    req_cyc = cyc;
    step();
  endtask

  task automatic wait_dv(input int bound);
    int base = dv_cnt;
    int n = 0;
    while (dv_cnt == base && n < bound) begin
      step();
      n++;
    end
    chk("dv_arrived", 32'(dv_cnt != base), 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (ocupado && n < bound) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(ocupado), 0);
  endtask

  task automatic do_frame(input logic [15:0] word);
    int r0, c0, d0, o0;
    adc_word = word;
    r0 = rises; c0 = cs_low; d0 = dv_cnt; o0 = ov_cnt;
    request();
    wait_dv(2 * LAT);
    chk("latency", 32'(dv_cyc - req_cyc), LAT);
    chk("dato", 32'(dv_dato), 32'(word[11:0]));
    wait_idle(4 * D);
    chk("sclk_rises", 32'(rises - r0), 16);
    chk("cs_low_cycles", 32'(cs_low - c0), 33 * D);
    chk("dv_pulses", 32'(dv_cnt - d0), 1);
    chk("no_overrun", 32'(ov_cnt - o0), 0);
  endtask

  initial begin
    int r0, c0, d0, o0, r1, r2, n;
    logic [15:0] w;
    logic [11:0] prev;

    // Reset with arbitrary inputs
    rst_n = 1'b0;
    enable = 1'($urandom);
    cm = 1'($urandom);
    step(5);
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_dato", 32'(dato), 0);
    chk("rst_dv", 32'(dato_valido), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Release with the sample clock already high: no conversion
    c0 = cs_low; d0 = dv_cnt;
    cm = 1'b1;
    enable = 1'b1;
    rst_n = 1'b1;
    step(60);
    chk("rel_no_cs", 32'(cs_low - c0), 0);
    chk("rel_no_busy", 32'(ocupado), 0);
    chk("rel_no_dv", 32'(dv_cnt - d0), 0);

    do_frame(16'h0A5C);

    // Overrun: second request 100 cycles into the frame
    w = {4'b0, 12'($urandom)};
    adc_word = w;
    r0 = rises; d0 = dv_cnt; o0 = ov_cnt;
    request();
    r1 = req_cyc;
    cm = 1'b0;
    while (cyc < r1 + 99) step();
    cm = 1'b1;
    step(3);
    wait_dv(2 * LAT);
    chk("ovr_dato", 32'(dv_dato), 32'(w[11:0]));
    wait_idle(4 * D);
    step(LAT + D);
    chk("ovr_pulses", 32'(ov_cnt - o0), 1);
    chk("ovr_frames", 32'(dv_cnt - d0), 1);
    chk("ovr_rises", 32'(rises - r0), 16);

    // Abort in the 8th SCLK period, with a request in the same cycle
    prev = dato;
    adc_word = {4'b0, 12'($urandom)};
    r0 = rises; d0 = dv_cnt;
    request();
    cm = 1'b0;
    n = 0;
    while ((rises - r0) < 7 && n < 2 * LAT) begin step(); n++; end
    while (sclk && n < 2 * LAT) begin step(); n++; end
    chk("abort_in_p8", 32'(rises - r0), 7);
    o0 = ov_cnt;
    enable = 1'b0;
    cm = 1'b1;
    step();
    chk("abort_cs_n", 32'(cs_n), 1);
    chk("abort_sclk", 32'(sclk), 1);
    chk("abort_ocupado", 32'(ocupado), 0);
    enable = 1'b1;
    step(LAT + D);
    chk("abort_no_dv", 32'(dv_cnt - d0), 0);
    chk("abort_dato_kept", 32'(dato), 32'(prev));
    chk("abort_no_ovr", 32'(ov_cnt - o0), 0);
    chk("abort_idle", 32'(ocupado), 0);

    // Reset in the middle of TRANSFER
    adc_word = {4'b0, 12'($urandom)};
    r0 = rises; d0 = dv_cnt;
    request();
    n = 0;
    while ((rises - r0) < 3 && n < 2 * LAT) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    chk("mrst_cs_n", 32'(cs_n), 1);
    chk("mrst_sclk", 32'(sclk), 1);
    chk("mrst_dato", 32'(dato), 0);
    chk("mrst_ocupado", 32'(ocupado), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("mrst_no_dv", 32'(dv_cnt - d0), 0);
    do_frame({4'b0, 12'($urandom)});

    // Back-to-back frames at minimum legal spacing
    step(5);
    adc_word = 16'h0FFF;
    d0 = dv_cnt; o0 = ov_cnt;
    request();
    r1 = req_cyc;
    step(5);
    cm = 1'b0;
    wait_dv(2 * LAT);
    chk("b2b_dato1", 32'(dv_dato), 32'h0FFF);
    chk("b2b_lat1", 32'(dv_cyc - r1), LAT);
    adc_word = 16'h0001;
    while (cyc < r1 + SP) step();
    cm = 1'b1;
    r2 = cyc;
    step();
    wait_dv(2 * LAT);
    chk("b2b_dato2", 32'(dv_dato), 32'h0001);
    chk("b2b_lat2", 32'(dv_cyc - r2), LAT);
    chk("b2b_cs_gap", 32'(last_hi_run >= D), 1);
    wait_idle(4 * D);
    chk("b2b_no_ovr", 32'(ov_cnt - o0), 0);
    chk("b2b_frames", 32'(dv_cnt - d0), 2);

    // Random frames with random gaps
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(1, 30));
      do_frame({4'b0, 12'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
